// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer width default and Gray/binary conversions for both FIFO controllers.
package fifo_pkg;

    localparam int POINTER_WIDTH_DEF = 4;
    localparam int PTR_MAX = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    // Callers zero-extend narrower pointers into ptr_t and slice the result back.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            sync_q   <= '0;
        end else begin
            stage1_q <= d;
            sync_q   <= stage1_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of an async FIFO; tracks the read pointer,
// synchronizes the Gray write pointer and derives empty, level and underflow.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int POINTER_WIDTH = POINTER_WIDTH_DEF
) (
    input  logic                     clk_r,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [POINTER_WIDTH:0]   w_ptr_g,
    output logic [POINTER_WIDTH:0]   r_ptr_g,
    output logic [POINTER_WIDTH-1:0] r_addr,
    output logic                     empty,
    output logic [POINTER_WIDTH:0]   rd_level,
    output logic                     underflow
);

    localparam int PW = POINTER_WIDTH;

    logic [PW:0] w_ptr_s;
    logic [PW:0] w_bin;
    logic [PW:0] r_bin_q, r_bin_d;
    logic [PW:0] r_ptr_g_q, r_ptr_g_d;
    logic        empty_q, empty_d;
    logic        underflow_q, underflow_d;
    logic        rd_ok;
    ptr_t        r_gray_x, w_bin_x;
    logic        unused_hi;

    sync_2ff #(.WIDTH(PW + 1)) u_sync (
        .clk (clk_r),
        .rst (rst),
        .d   (w_ptr_g),
        .q   (w_ptr_s)
    );

    always_comb begin
        rd_ok       = rd_en & ~empty_q;
        r_bin_d     = r_bin_q + {{PW{1'b0}}, rd_ok};
        r_gray_x    = bin2gray(ptr_t'(r_bin_d));
        r_ptr_g_d   = r_gray_x[PW:0];
        // Compare against the pointer synchronized so far; a write arriving on this edge clears empty next edge.
        empty_d     = r_ptr_g_d == w_ptr_s;
        underflow_d = rd_en & empty_q;
        w_bin_x     = gray2bin(ptr_t'(w_ptr_s));
        w_bin       = w_bin_x[PW:0];
    end

    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            r_bin_q     <= '0;
            r_ptr_g_q   <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            r_bin_q     <= r_bin_d;
            r_ptr_g_q   <= r_ptr_g_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    assign unused_hi = ^{r_gray_x[PTR_MAX-1:PW+1], w_bin_x[PTR_MAX-1:PW+1]};
    assign r_ptr_g   = r_ptr_g_q;
    assign r_addr    = r_bin_q[PW-1:0];
    assign empty     = empty_q;
    assign underflow = underflow_q;
    assign rd_level  = w_bin - r_bin_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed vector table plus corner sequences and a constrained random run.
module tb_fifo_rd_ctrl;

    logic       clk_r = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] w_ptr_g = '0;
    logic [4:0] r_ptr_g;
    logic [3:0] r_addr;
    logic       empty;
    logic [4:0] rd_level;
    logic       underflow;

    int n_chk = 0;
    int n_fail = 0;

    fifo_rd_ctrl #(.POINTER_WIDTH(4)) dut (
        .clk_r     (clk_r),
        .rst       (rst),
        .rd_en     (rd_en),
        .w_ptr_g   (w_ptr_g),
        .r_ptr_g   (r_ptr_g),
        .r_addr    (r_addr),
        .empty     (empty),
        .rd_level  (rd_level),
        .underflow (underflow)
    );

    always #5 clk_r = ~clk_r;

    typedef struct {
        logic       rd;
        logic [4:0] w;
        logic [3:0] addr;
        logic [4:0] gptr;
        logic       emp;
        logic [4:0] lvl;
        logic       uf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rd, input logic [4:0] w);
        @(negedge clk_r);
        rd_en = rd;
        w_ptr_g = w;
        @(posedge clk_r);
        #1;
    endtask

    task automatic check_all(input string nm, input logic [3:0] a, input logic [4:0] g,
                             input logic e, input logic [4:0] l, input logic u);
        chk({nm, ".r_addr"}, int'(r_addr), int'(a));
        chk({nm, ".r_ptr_g"}, int'(r_ptr_g), int'(g));
        chk({nm, ".empty"}, int'(empty), int'(e));
        chk({nm, ".rd_level"}, int'(rd_level), int'(l));
        chk({nm, ".underflow"}, int'(underflow), int'(u));
    endtask

    task automatic do_reset();
        @(negedge clk_r);
        rd_en = 1'b0;
        w_ptr_g = '0;
        rst = 1'b1;
        @(negedge clk_r);
        rst = 1'b0;
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    initial begin
        logic [4:0] w_bin, prev_g, model_r;
        logic       prev_rd, prev_emp;

        tbl[0]  = '{1'b0, 5'b00010, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};
        tbl[1]  = '{1'b0, 5'b00010, 4'd0, 5'b00000, 1'b1, 5'd3,  1'b0};
        tbl[2]  = '{1'b0, 5'b00010, 4'd0, 5'b00000, 1'b0, 5'd3,  1'b0};
        tbl[3]  = '{1'b1, 5'b00010, 4'd1, 5'b00001, 1'b0, 5'd2,  1'b0};
        tbl[4]  = '{1'b1, 5'b00010, 4'd2, 5'b00011, 1'b0, 5'd1,  1'b0};
        tbl[5]  = '{1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b0};
        tbl[6]  = '{1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b1};
        tbl[7]  = '{1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b0};
        tbl[8]  = '{1'b0, 5'b11000, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b0};
        tbl[9]  = '{1'b0, 5'b11000, 4'd3, 5'b00010, 1'b1, 5'd13, 1'b0};
        tbl[10] = '{1'b0, 5'b11000, 4'd3, 5'b00010, 1'b0, 5'd13, 1'b0};

        // Asynchronous reset with no clock edge in between
        #1 rst = 1'b1;
        #1 check_all("reset", 4'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk_r);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rd, tbl[i].w);
            check_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].gptr, tbl[i].emp, tbl[i].lvl, tbl[i].uf);
        end

        // Drain to r_bin=15 against a write pointer of 16
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 5'b11000);
            chk($sformatf("drain%0d.r_addr", k), int'(r_addr), (3 + k) % 16);
        end
        check_all("pre_wrap", 4'd15, 5'b01000, 1'b0, 5'd1, 1'b0);
        // Write pointer 17 reaches w_ptr_s on the same edge as the final read
        step(1'b0, 5'b11001);
        check_all("wrap_stage", 4'd15, 5'b01000, 1'b0, 5'd1, 1'b0);
        step(1'b1, 5'b11001);
        check_all("wrap_read", 4'd0, 5'b11000, 1'b1, 5'd1, 1'b0);
        step(1'b0, 5'b11001);
        check_all("wrap_clear", 4'd0, 5'b11000, 1'b0, 5'd1, 1'b0);

        // Full level from reset
        do_reset();
        step(1'b0, 5'b11000);
        check_all("full1", 4'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step(1'b0, 5'b11000);
        check_all("full2", 4'd0, 5'd0, 1'b1, 5'd16, 1'b0);
        step(1'b0, 5'b11000);
        check_all("full3", 4'd0, 5'd0, 1'b0, 5'd16, 1'b0);

        // Mid-run asynchronous reset at r_bin=5
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 5'b01100);
        for (int k = 0; k < 5; k++) step(1'b1, 5'b01100);
        check_all("midrun", 4'd5, 5'b00111, 1'b0, 5'd3, 1'b0);
        #2 rst = 1'b1;
        #1 check_all("midrun_rst", 4'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk_r);
        rst = 1'b0;
        rd_en = 1'b0;
        w_ptr_g = '0;

        // Random traffic; the writer never runs more than 16 ahead of the read pointer it observes
        w_bin = '0;
        model_r = '0;
        prev_g = r_ptr_g;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_r);
            rd_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1 && 5'(w_bin - g2b(r_ptr_g)) < 5'd16) w_bin = w_bin + 5'd1;
            w_ptr_g = w_bin ^ (w_bin >> 1);
            prev_rd = rd_en;
            prev_emp = empty;
            prev_g = r_ptr_g;
            @(posedge clk_r);
            #1;
            if (prev_rd && !prev_emp) model_r = model_r + 5'd1;
            chk("rand.gray_step", int'($countones(r_ptr_g ^ prev_g) <= 1), 1);
            chk("rand.level_max", int'(rd_level <= 5'd16), 1);
            chk("rand.r_addr", int'(r_addr), int'(model_r[3:0]));
            chk("rand.underflow", int'(underflow), int'(prev_rd & prev_emp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter POINTER_WIDTH, default 4, address width; depth = 2**POINTER_WIDTH entries; pointers are POINTER_WIDTH+1 bits.
REQ-002 SHALL have port clk_r  input  1  read-domain clock; all state on rising edge; one clock only.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rd_en  input  1  read request from consumer.
REQ-005 SHALL have port w_ptr_g  input  POINTER_WIDTH+1  Gray write pointer from write domain, asynchronous to clk_r.
REQ-006 SHALL have port r_ptr_g  output  POINTER_WIDTH+1  registered Gray read pointer to write domain.
REQ-007 SHALL have port r_addr  output  POINTER_WIDTH  RAM read address = low POINTER_WIDTH bits of binary read pointer.
REQ-008 SHALL have port empty  output  1  registered empty flag.
REQ-009 SHALL have port rd_level  output  POINTER_WIDTH+1  entries available, 0..2**POINTER_WIDTH.
REQ-010 SHALL have port underflow  output  1  one-cycle pulse on rejected read.

Function
REQ-011 SHALL synchronize w_ptr_g through exactly two clk_r flops (stage1, w_ptr_s); no logic between stages.
REQ-012 SHALL accept a read when rd_en=1 and empty=0; r_bin increments by 1 on that edge, modulo 2**(POINTER_WIDTH+1).
REQ-013 SHALL hold r_bin when rd_en=0 or empty=1.
REQ-014 SHALL register r_ptr_g = r_bin_next ^ (r_bin_next >> 1) on the same edge as r_bin; r_ptr_g only ever changes by one bit per clk_r edge.
REQ-015 SHALL register empty = (Gray of r_bin_next == w_ptr_s); an accepted read that consumes the last entry asserts empty on that edge.
REQ-016 SHALL deassert empty no earlier than the 3rd clk_r rising edge after w_ptr_g changes (2 sync + 1 flag).
REQ-017 SHALL compute rd_level combinationally = gray2bin(w_ptr_s) - r_bin, modulo 2**(POINTER_WIDTH+1); value 2**POINTER_WIDTH means full.
REQ-018 SHALL register underflow = rd_en & empty for one cycle; pointers unchanged on underflow.
REQ-019 SHALL handle wrap-around: MSB of r_bin toggles when r_addr wraps from all-ones to 0; empty/level remain correct across wrap.
REQ-020 SHALL treat a simultaneous write-pointer advance and final read correctly: empty uses w_ptr_s as sampled that edge; a newly synchronized write clears empty on the following edge.

Reset
REQ-021 SHALL, while rst=1, force immediately without clock: r_bin=0, r_ptr_g=0, r_addr=0, both sync stages=0, empty=1, underflow=0, rd_level=0.
REQ-022 SHALL resume normal operation on the first clk_r edge after rst deasserts; reset mid-operation discards all state.

Structure
REQ-023 SHALL place POINTER_WIDTH default and bin2gray/gray2bin functions in shared package fifo_pkg, used also by the write-side controller.
REQ-024 SHALL instantiate one sub-module sync_2ff (parameterized width, clock, async active-high reset) for the w_ptr_g synchronizer.
REQ-025 SHALL contain no combinational path from w_ptr_g to any output.

Verification (POINTER_WIDTH=4)
REQ-026 Reset: rst=1 with r_bin=5 mid-run, no clock -> r_ptr_g=0, r_addr=0, empty=1, rd_level=0, underflow=0 immediately.
REQ-027 Latency: w_ptr_g 00000->00010 (bin 3), rd_en=0 -> rd_level=3 after 2nd edge, empty=0 after 3rd edge.
REQ-028 Drain: then rd_en=1 for 4 cycles -> r_addr 0,1,2,3; r_ptr_g 00001,00011,00010,00010; empty=1 with 3rd read; underflow=1 on 4th cycle only.
REQ-029 Wrap: w_ptr_g=11000 (bin 16), r_bin from 15 -> after one read r_addr 15->0, r_ptr_g=11000, empty=1.
REQ-030 Full level: r_bin=0, w_ptr_g=11000 synchronized -> rd_level=16, empty=0.
REQ-031 Gray check: random reads/writes 1000 cycles -> every r_ptr_g change has Hamming distance 1; rd_level never exceeds 16.
